trajectory_frame_scheduler: RTL and testbench



---
 rtl/traj_pkg.sv | 18 +
 rtl/trajectory_frame_scheduler_if.sv | 14 +
 rtl/traj_slot_bank.sv | 50 +++++
 rtl/trajectory_frame_scheduler.sv | 117 +++++++++++
 tb/tb_trajectory_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/traj_pkg.sv
// Shared types and constants for the per-frame trajectory scheduler.
package traj_pkg;

  localparam int unsigned MAX_BALLS  = 7;
  localparam int unsigned X_W        = 11;
  localparam int unsigned Y_W        = 10;
  localparam int unsigned BALL_IDX_W = 3;

  typedef logic [X_W-1:0]        coord_x_t;
  typedef logic [Y_W-1:0]        coord_y_t;
  typedef logic [BALL_IDX_W-1:0] ball_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/trajectory_frame_scheduler_if.sv
// Request/acknowledge link between the scheduler and the shared trajectory evaluator.
interface trajectory_frame_scheduler_if;
  import traj_pkg::*;

  logic      eval_req;
  ball_idx_t eval_idx;
  logic      eval_ack;
  coord_x_t  eval_x;
  coord_y_t  eval_y;

  modport master (output eval_req, output eval_idx, input eval_ack, input eval_x, input eval_y);
  modport slave  (input eval_req, input eval_idx, output eval_ack, output eval_x, output eval_y);

endinterface

// File: rtl/traj_slot_bank.sv
// Shadow and committed position registers for every ball slot.
module traj_slot_bank
  import traj_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  ball_idx_t                wr_idx,
  input  coord_x_t                 wr_x,
  input  coord_y_t                 wr_y,
  input  logic                     clr_en,
  input  ball_idx_t                clr_nb,
  input  logic                     commit,
  output coord_x_t [MAX_BALLS-1:0] act_x,
  output coord_y_t [MAX_BALLS-1:0] act_y
);

  coord_x_t [MAX_BALLS-1:0] sh_x;
  coord_y_t [MAX_BALLS-1:0] sh_y;

  // Shadow slots: filled by transfers, unused slots zeroed at sweep launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x <= '0;
      sh_y <= '0;
    end else begin
      for (int unsigned i = 0; i < MAX_BALLS; i++) begin
        if (clr_en && (BALL_IDX_W'(i) >= clr_nb)) begin
          sh_x[i] <= '0;
          sh_y[i] <= '0;
        end else if (wr_en && (wr_idx == BALL_IDX_W'(i))) begin
          sh_x[i] <= wr_x;
          sh_y[i] <= wr_y;
        end
      end
    end
  end

  // Committed slots: whole set copied at once so the renderer never sees a partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_x <= '0;
      act_y <= '0;
    end else if (commit) begin
      act_x <= sh_x;
      act_y <= sh_y;
    end
  end

endmodule

// File: rtl/trajectory_frame_scheduler.sv
// Collects one position per ball each frame and commits the set at the next frame start.
module trajectory_frame_scheduler
  import traj_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4095
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_start,
  input  ball_idx_t                     num_balls,
  trajectory_frame_scheduler_if.master  ev,
  output coord_x_t [MAX_BALLS-1:0]      traj_x_out,
  output coord_y_t [MAX_BALLS-1:0]      traj_y_out,
  output logic                          traj_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int unsigned       WAIT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);

  sched_state_t      state;
  ball_idx_t         idx;
  ball_idx_t         nb;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pending_commit;
  logic              req;

  logic              launch_c;
  logic              commit_c;
  logic              xfer_c;
  logic [WAIT_W-1:0] wait_inc_c;

  assign launch_c   = (state == IDLE) && frame_start;
  assign commit_c   = launch_c && pending_commit;
  assign xfer_c     = (state == REQ) && ev.eval_ack;
  assign wait_inc_c = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + WAIT_W'(1);

  assign ev.eval_req = req;
  assign ev.eval_idx = idx;

  // Sweep sequencer: launch on frame start, walk ball indices, abort on a stalled evaluator.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      req            <= 1'b0;
      busy           <= 1'b0;
      idx            <= '0;
      nb             <= '0;
      wait_cnt       <= '0;
      pending_commit <= 1'b0;
      traj_valid     <= 1'b0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            if (pending_commit) traj_valid <= 1'b1;
            nb       <= num_balls;
            idx      <= '0;
            wait_cnt <= '0;
            if (num_balls == '0) begin
              pending_commit <= 1'b1;
            end else begin
              pending_commit <= 1'b0;
              state          <= REQ;
              req            <= 1'b1;
              busy           <= 1'b1;
            end
          end
        end
        REQ: begin
          if (frame_start) overrun <= 1'b1;
          if (ev.eval_ack) begin
            wait_cnt <= '0;
            if (idx == nb - BALL_IDX_W'(1)) begin
              state          <= IDLE;
              req            <= 1'b0;
              busy           <= 1'b0;
              pending_commit <= 1'b1;
            end else begin
              idx <= idx + BALL_IDX_W'(1);
            end
          end else if (wait_inc_c == WAIT_LIMIT) begin
            state    <= IDLE;
            req      <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  traj_slot_bank u_slot_bank (
    .clk    (clk_in),
    .rst    (rst_in),
    .wr_en  (xfer_c),
    .wr_idx (idx),
    .wr_x   (ev.eval_x),
    .wr_y   (ev.eval_y),
    .clr_en (launch_c),
    .clr_nb (num_balls),
    .commit (commit_c),
    .act_x  (traj_x_out),
    .act_y  (traj_y_out)
  );

endmodule

// File: tb/tb_trajectory_frame_scheduler.sv
// Bench for trajectory_frame_scheduler: evaluator responder, reference model, directed and random frames.
module tb_trajectory_frame_scheduler;
  import traj_pkg::*;

  localparam int unsigned TO = 16;

  logic      clk_in = 1'b0;
  logic      rst_in = 1'b1;
  logic      frame_start = 1'b0;
  ball_idx_t num_balls = '0;

  coord_x_t [MAX_BALLS-1:0] traj_x_out;
  coord_y_t [MAX_BALLS-1:0] traj_y_out;
  logic traj_valid, busy, overrun, timeout;

  trajectory_frame_scheduler_if bus ();

  trajectory_frame_scheduler #(.ACK_TIMEOUT(TO)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .num_balls   (num_balls),
    .ev          (bus),
    .traj_x_out  (traj_x_out),
    .traj_y_out  (traj_y_out),
    .traj_valid  (traj_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Evaluator behaviour knobs.
  int ev_delay = 0;
  bit ev_rand  = 0;
  int ev_xb    = 0;
  int ev_yb    = 0;
  int d_wait   = 0;
  bit d_prev_req = 0;

  // Reference model: what the renderer should see, derived from frame and transfer events.
  bit m_busy = 0, m_pend = 0, m_valid = 0;
  int m_idx = 0, m_nb = 0, m_wait = 0;
  coord_x_t [MAX_BALLS-1:0] m_sh_x = '0, m_act_x = '0;
  coord_y_t [MAX_BALLS-1:0] m_sh_y = '0, m_act_y = '0;

  // Each falling edge: advance the model over the last rising edge, compare, then respond as the evaluator.
  always @(negedge clk_in) begin : model_and_evaluator
    bit old_busy, o_exp, t_exp;
    if (rst_in) begin
      m_busy = 0; m_pend = 0; m_valid = 0; m_idx = 0; m_nb = 0; m_wait = 0;
      m_sh_x = '0; m_sh_y = '0; m_act_x = '0; m_act_y = '0;
      bus.eval_ack = 1'b0; bus.eval_x = '0; bus.eval_y = '0;
      d_wait = 0; d_prev_req = 0;
    end else begin
      old_busy = m_busy; o_exp = 0; t_exp = 0;
      if (old_busy) begin
        if (bus.eval_ack) begin
          m_sh_x[m_idx] = bus.eval_x;
          m_sh_y[m_idx] = bus.eval_y;
          m_wait = 0;
          if (m_idx == m_nb - 1) begin m_busy = 0; m_pend = 1; end
          else m_idx++;
        end else begin
          m_wait++;
          if (m_wait == int'(TO)) begin m_busy = 0; t_exp = 1; end
        end
      end
      if (frame_start) begin
        if (old_busy) o_exp = 1;
        else begin
          if (m_pend) begin m_act_x = m_sh_x; m_act_y = m_sh_y; m_valid = 1; m_pend = 0; end
          m_nb = int'(num_balls);
          for (int i = m_nb; i < int'(MAX_BALLS); i++) begin m_sh_x[i] = '0; m_sh_y[i] = '0; end
          if (m_nb == 0) m_pend = 1;
          else begin m_busy = 1; m_idx = 0; m_wait = 0; end
        end
      end
      check("ctrl",
            256'({bus.eval_req, busy, overrun, timeout, traj_valid, (bus.eval_req ? bus.eval_idx : 3'd0)}),
            256'({m_busy, m_busy, o_exp, t_exp, m_valid, (m_busy ? 3'(m_idx) : 3'd0)}));
      check("slots", 256'({traj_x_out, traj_y_out}), 256'({m_act_x, m_act_y}));

      if (d_prev_req && bus.eval_ack) d_wait = 0;
      if (bus.eval_req && d_wait >= ev_delay) begin
        bus.eval_ack = 1'b1;
        if (ev_rand) begin
          bus.eval_x = X_W'($urandom);
          bus.eval_y = Y_W'($urandom);
        end else begin
          bus.eval_x = X_W'(ev_xb + int'(bus.eval_idx));
          bus.eval_y = Y_W'(ev_yb + int'(bus.eval_idx));
        end
      end else begin
        bus.eval_ack = 1'b0;
        if (bus.eval_req) d_wait++;
      end
      d_prev_req = bus.eval_req;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (busy && cyc < bound) begin cyc++; tick(); end
    if (cyc >= bound) check("idle_bound", 256'(busy), 256'(0));
  endtask

  typedef struct {
    int nb; int delay; int xb; int yb; int cyc;
    coord_x_t [MAX_BALLS-1:0] ex;
    coord_y_t [MAX_BALLS-1:0] ey;
  } vec_t;

  vec_t tbl [4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int cyc, n, ov;
    tbl[0] = '{nb: 3, delay: 0, xb: 100, yb: 50, cyc: 3,
               ex: {11'd0, 11'd0, 11'd0, 11'd0, 11'd102, 11'd101, 11'd100},
               ey: {10'd0, 10'd0, 10'd0, 10'd0, 10'd52, 10'd51, 10'd50}};
    tbl[1] = '{nb: 7, delay: 5, xb: 200, yb: 300, cyc: 42,
               ex: {11'd206, 11'd205, 11'd204, 11'd203, 11'd202, 11'd201, 11'd200},
               ey: {10'd306, 10'd305, 10'd304, 10'd303, 10'd302, 10'd301, 10'd300}};
    tbl[2] = '{nb: 0, delay: 0, xb: 0, yb: 0, cyc: 0, ex: '0, ey: '0};
    tbl[3] = '{nb: 1, delay: 2, xb: 7, yb: 9, cyc: 3,
               ex: {11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd7},
               ey: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd9}};

    tick(3);
    rst_in = 1'b0;
    tick(2);
    check("rst_outputs", 256'({bus.eval_req, busy, traj_valid, overrun, timeout}), 256'(0));
    check("rst_slots", 256'({traj_x_out, traj_y_out}), 256'(0));

    // Table: launch a sweep, measure its length, commit it with the next frame start.
    for (int r = 0; r < 4; r++) begin
      ev_rand = 0; ev_delay = tbl[r].delay; ev_xb = tbl[r].xb; ev_yb = tbl[r].yb;
      num_balls = 3'(tbl[r].nb);
      pulse_fs();
      wait_idle(200, cyc);
      check($sformatf("sweep_cycles_%0d", r), 256'(cyc), 256'(tbl[r].cyc));
      tick(2);
      pulse_fs();
      check($sformatf("commit_x_%0d", r), 256'(traj_x_out), 256'(tbl[r].ex));
      check($sformatf("commit_y_%0d", r), 256'(traj_y_out), 256'(tbl[r].ey));
      check($sformatf("valid_%0d", r), 256'(traj_valid), 256'(1));
      wait_idle(200, cyc);
    end

    // Evaluator never answers: request held for exactly the timeout, no commit afterwards.
    num_balls = 3'd2; ev_delay = 1000;
    pulse_fs();
    n = 0;
    while (bus.eval_req && n < 100) begin n++; tick(); end
    check("timeout_req_cycles", 256'(n), 256'(TO));
    check("timeout_pulse", 256'(timeout), 256'(1));
    tick();
    ev_delay = 0; ev_xb = 40; ev_yb = 45;
    pulse_fs();
    check("timeout_keep_x", 256'(traj_x_out), 256'(tbl[3].ex));
    check("timeout_keep_valid", 256'(traj_valid), 256'(1));
    wait_idle(200, cyc);

    // Slow sweep spanning a frame boundary.
    num_balls = 3'd4; ev_delay = 10; ev_xb = 500; ev_yb = 600;
    pulse_fs();
    ov = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 24 || c == 49) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (overrun) ov++;
    end
    check("overrun_count", 256'(ov), 256'(1));
    check("slow_commit_x", 256'(traj_x_out),
          256'({11'd0, 11'd0, 11'd0, 11'd503, 11'd502, 11'd501, 11'd500}));
    check("slow_commit_y", 256'(traj_y_out),
          256'({10'd0, 10'd0, 10'd0, 10'd603, 10'd602, 10'd601, 10'd600}));
    check("slow_relaunch", 256'(busy), 256'(1));
    wait_idle(200, cyc);

    // Reset in the middle of a sweep.
    num_balls = 3'd5; ev_delay = 0; ev_xb = 20; ev_yb = 30;
    pulse_fs();
    n = 0;
    while (!(bus.eval_req && bus.eval_idx == 3'd2) && n < 20) begin n++; tick(); end
    check("reach_idx2", 256'(bus.eval_idx), 256'(2));
    rst_in = 1'b1;
    #1;
    check("async_rst_ctrl", 256'({bus.eval_req, busy, traj_valid}), 256'(0));
    check("async_rst_slots", 256'({traj_x_out, traj_y_out}), 256'(0));
    tick();
    rst_in = 1'b0;
    tick();
    pulse_fs();
    check("fresh_sweep", 256'({bus.eval_req, bus.eval_idx}), 256'({1'b1, 3'd0}));
    wait_idle(200, cyc);
    tick();
    pulse_fs();
    check("fresh_commit_x", 256'(traj_x_out),
          256'({11'd0, 11'd0, 11'd24, 11'd23, 11'd22, 11'd21, 11'd20}));
    wait_idle(200, cyc);

    // Random frames, ball counts, evaluator latencies and data against the model.
    ev_rand = 1;
    repeat (60) begin
      num_balls = 3'($urandom_range(0, 7));
      ev_delay  = $urandom_range(0, 20);
      pulse_fs();
      repeat ($urandom_range(1, 80)) begin
        if ($urandom_range(0, 7) == 0) num_balls = 3'($urandom_range(0, 7));
        tick();
      end
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
